// File: rtl/cache_array_pkg.sv
// Shared types and helpers for the cache_array storage block.
// Holds the FSM state type and the byte-mask merge used for writes and forwarding.
package cache_array_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  // Widest entry the merge helper supports; callers size-cast in and out.
  localparam int unsigned MaxWidth = 256;
  localparam int unsigned MaxBytes = MaxWidth / 8;

  function automatic logic [MaxWidth-1:0] merge_bytes(input logic [MaxWidth-1:0] old_data,
                                                      input logic [MaxWidth-1:0] new_data,
                                                      input logic [MaxBytes-1:0] mask);
    logic [MaxWidth-1:0] res;
    res = old_data;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      if (mask[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_array.sv
// Byte-maskable register-file array with combinational read, optional write forwarding,
// and a one-entry-per-cycle clear sweep that also runs after reset.
module cache_array
  import cache_array_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_BITS = 4,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIDTH/8-1:0]  wmask,
  input  logic [IDX_BITS-1:0] windex,
  input  logic [WIDTH-1:0]    datain,
  input  logic [IDX_BITS-1:0] rindex,
  output logic [WIDTH-1:0]    dataout,
  input  logic                clear,
  output logic                busy
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    merged;
  logic                wr_en;

  assign merged = WIDTH'(merge_bytes(MaxWidth'(mem[windex]), MaxWidth'(datain),
                                     MaxBytes'(wmask)));
  // A clear request in the same idle cycle drops the write.
  assign wr_en  = (state_q == StIdle) && load && !clear;
  assign busy   = (state_q == StClear);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_BITS'(DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset leaves storage untouched on its edge; the following sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        mem[windex] <= merged;
      end
    end
  end

  always_comb begin
    dataout = '0;
    if (state_q == StIdle) begin
      dataout = mem[rindex];
      if (BYPASS && load && (rindex == windex)) dataout = merged;
    end
  end

endmodule

// File: doc/cache_array.md
CACHE_ARRAY -- requirements
Module: cache_array

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry; SHALL be a multiple of 8.
REQ-002 Parameter IDX_BITS, default 4, index width; DEPTH = 2**IDX_BITS entries.
REQ-003 Parameter BYPASS, default 0, 1 = write-to-read forwarding on same-cycle index match.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  write strobe for windex.
REQ-007 wmask  input  WIDTH/8  byte enables; bit i covers datain[8i+7:8i].
REQ-008 windex  input  IDX_BITS  write index.
REQ-009 datain  input  WIDTH  write data.
REQ-010 rindex  input  IDX_BITS  read index.
REQ-011 dataout  output  WIDTH  combinational read data.
REQ-012 clear  input  1  single-cycle request to zero every entry.
REQ-013 busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 Storage SHALL be DEPTH entries of WIDTH bits, all zero at time 0.
REQ-015 Read SHALL be combinational: dataout = entry[rindex] with zero-cycle latency when busy=0.
REQ-016 Write in IDLE with load=1: each byte i with wmask[i]=1 takes datain byte i at the edge; bytes with wmask[i]=0 keep their old value.
REQ-017 load=1 with wmask=0 SHALL leave the entry unchanged.
REQ-018 BYPASS=0: a same-cycle read of windex SHALL return the pre-write value; the new value is visible from the next cycle.
REQ-019 BYPASS=1, load=1, rindex==windex, busy=0: dataout SHALL equal the byte-merged write value in the same cycle.
REQ-020 FSM states IDLE and CLEAR, with a sweep counter cnt of IDX_BITS bits.
REQ-021 IDLE with clear=1: go to CLEAR with cnt=0 at the next edge.
REQ-022 In CLEAR, each edge SHALL zero entry[cnt] and increment cnt; at cnt==DEPTH-1, zero that entry and return to IDLE.
REQ-023 A full sweep SHALL take exactly DEPTH cycles in CLEAR.
REQ-024 busy SHALL be 1 exactly when the state is CLEAR.
REQ-025 While busy=1, dataout SHALL be all-zero and load SHALL be ignored (no entry modified by load).
REQ-026 clear asserted while busy=1 SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-027 clear=1 and load=1 in the same IDLE cycle: clear wins and the write SHALL be dropped.
REQ-028 The first load accepted after a sweep is the one presented in the cycle busy=0.

Reset
REQ-029 rst=1 at an edge SHALL force state CLEAR and cnt=0, with no entry written on that edge.
REQ-030 After rst deasserts, the full DEPTH-cycle sweep SHALL run, with busy=1 and dataout=0 throughout.
REQ-031 rst asserted mid-sweep or mid-write SHALL restart the sweep from cnt=0; rst has priority over clear and load.
REQ-032 Reset values: busy=1 and dataout=0 from the first cycle after the rst edge.

Structure
REQ-033 A shared package cache_array_pkg SHALL hold the state enum (IDLE, CLEAR) and a function that merges old data, new data and byte mask.
REQ-034 There SHALL be no sub-module: one storage array plus the FSM and counter in a single module.
REQ-035 Storage SHALL be an unpacked array, written in a single always_ff and read in always_comb.

Verification
REQ-036 rst 1 cycle, then idle 16 cycles (IDX_BITS=4) -> busy=1 for exactly 16 cycles, then 0; all reads return 0.
REQ-037 Write idx 3 datain=0xAABBCCDD wmask=0xF, then write idx 3 datain=0x11223344 wmask=0x5 -> read idx 3 = 0xAA22CC44.
REQ-038 Same cycle load idx 5 = 0xDEADBEEF, rindex=5 -> BYPASS=0 reads the old value then 0xDEADBEEF next cycle; BYPASS=1 reads 0xDEADBEEF in the same cycle.
REQ-039 Fill all 16 entries nonzero, pulse clear together with load idx 2 -> write dropped; after 16 busy cycles all entries read 0.
REQ-040 clear pulsed at sweep cycle 7 and load held during the sweep -> busy lasts 16 cycles total and no entry is modified.
REQ-041 rst at sweep cycle 10 -> busy restarts and stays 1 for 16 more cycles after rst drops; entries read 0 afterwards.
